// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin req/gnt/ack arbiter sharing one memory port between fetch (0) and data (1).
// Optional MEM_ARB_LOCK_EN adds lock0/lock1 so a locked owner keeps the memory for atomic RMW.
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
`ifdef MEM_ARB_LOCK_EN
  input  logic                  lock0,
  input  logic                  lock1,
`endif
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t     state;
  logic [3:0] wcnt;
  logic       last, owner, pick, hold;
`ifdef MEM_ARB_LOCK_EN
  logic locked;
  assign hold = locked && (owner ? req1 : req0);
  always_ff @(posedge clock or posedge reset)
    if (reset) locked <= 1'b0;
    else if (state == IDLE && (req0 || req1)) locked <= pick ? lock1 : lock0;
`else
  assign hold = 1'b0;
`endif
  // A held lock keeps the previous owner; otherwise a tie goes to the port that did not go last.
  assign pick = hold ? owner : (req0 && req1 ? !last : req1);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state     <= IDLE;
      wcnt      <= '0;
      last      <= 1'b1;
      owner     <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata     <= '0;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (req0 || req1) begin
          owner     <= pick;
          gnt0      <= !pick;
          gnt1      <= pick;
          mem_cs    <= 1'b1;
          mem_we    <= pick ? we1 : we0;
          mem_addr  <= pick ? addr1 : addr0;
          mem_wdata <= pick ? wdata1 : wdata0;
          wcnt      <= 4'(WAIT_STATES - 1);
          state     <= ACCESS;
        end
        ACCESS: if (wcnt == 4'd0) begin
          if (!mem_we) rdata <= mem_rdata;
          mem_cs <= 1'b0;
          mem_we <= 1'b0;
          ack0   <= !owner;
          ack1   <= owner;
          last   <= owner;
          state  <= DONE;
        end else wcnt <= wcnt - 4'd1;
        DONE: begin
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of the memory arbiter with WAIT_STATES=2.
module tb_mem_arbiter;
  logic        clock = 1'b0, reset = 1'b0;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [15:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0, mem_rdata = 0;
  logic        gnt0, gnt1, ack0, ack1, mem_cs, mem_we;
  logic [15:0] rdata, mem_addr, mem_wdata;
`ifdef MEM_ARB_LOCK_EN
  logic        lock0 = 0, lock1 = 0;
`endif
  int errors = 0, checks = 0;

  mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .WAIT_STATES(2)) dut (
    .clock(clock), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
`ifdef MEM_ARB_LOCK_EN
    .lock0(lock0), .lock1(lock1),
`endif
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1), .rdata(rdata),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata));

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // {gnt0,gnt1,mem_cs,mem_we,ack0,ack1}
  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({gnt0, gnt1, mem_cs, mem_we, ack0, ack1} !== 6'b0 || rdata !== 16'h0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: ctl=%b rdata=%h addr=%h wdata=%h want all zero", {gnt0, gnt1, mem_cs, mem_we, ack0, ack1}, rdata, mem_addr, mem_wdata);
    end
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_read();
    req0 = 1; we0 = 0; addr0 = 16'h0040; mem_rdata = 16'hBEEF;
    tick();
    checks++;
    if ({gnt0, gnt1, mem_cs, mem_we, ack0, ack1} !== 6'b101000 || mem_addr !== 16'h0040) begin
      errors++;
      $display("FAIL read_grant: ctl=%b addr=%h want 101000 0040", {gnt0, gnt1, mem_cs, mem_we, ack0, ack1}, mem_addr);
    end
    tick();
    checks++;
    if ({gnt0, gnt1, mem_cs, mem_we, ack0, ack1} !== 6'b101000) begin
      errors++;
      $display("FAIL read_access2: ctl=%b want 101000", {gnt0, gnt1, mem_cs, mem_we, ack0, ack1});
    end
    tick();
    checks++;
    if ({gnt0, gnt1, mem_cs, mem_we, ack0, ack1} !== 6'b100010 || rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL read_ack: ctl=%b rdata=%h want 100010 beef", {gnt0, gnt1, mem_cs, mem_we, ack0, ack1}, rdata);
    end
    req0 = 0;
    tick();
    checks++;
    if ({gnt0, gnt1, mem_cs, mem_we, ack0, ack1} !== 6'b0) begin
      errors++;
      $display("FAIL read_release: ctl=%b want 000000", {gnt0, gnt1, mem_cs, mem_we, ack0, ack1});
    end
  endtask

  task automatic test_write();
    req1 = 1; we1 = 1; addr1 = 16'h1234; wdata1 = 16'h00FF; mem_rdata = 16'h1111;
    tick();
    checks++;
    if ({gnt0, gnt1, mem_cs, mem_we, ack0, ack1} !== 6'b011100 || mem_addr !== 16'h1234 || mem_wdata !== 16'h00FF) begin
      errors++;
      $display("FAIL write_grant: ctl=%b addr=%h wdata=%h want 011100 1234 00ff", {gnt0, gnt1, mem_cs, mem_we, ack0, ack1}, mem_addr, mem_wdata);
    end
    addr1 = 16'hFFFF; wdata1 = 16'hAAAA; we1 = 0;
    tick();
    checks++;
    if ({gnt0, gnt1, mem_cs, mem_we, ack0, ack1} !== 6'b011100 || mem_addr !== 16'h1234 || mem_wdata !== 16'h00FF) begin
      errors++;
      $display("FAIL write_latched: ctl=%b addr=%h wdata=%h want 011100 1234 00ff", {gnt0, gnt1, mem_cs, mem_we, ack0, ack1}, mem_addr, mem_wdata);
    end
    tick();
    checks++;
    if ({gnt0, gnt1, mem_cs, mem_we, ack0, ack1} !== 6'b010001 || rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL write_ack: ctl=%b rdata=%h want 010001 beef", {gnt0, gnt1, mem_cs, mem_we, ack0, ack1}, rdata);
    end
    req1 = 0;
    tick();
  endtask

  task automatic test_contention();
    logic [1:0] want;
    req0 = 1; req1 = 1; we0 = 0; we1 = 0;
    for (int k = 0; k < 4; k++) begin
      want = k[0] ? 2'b01 : 2'b10;
      tick();
      checks++;
      if ({gnt0, gnt1} !== want) begin
        errors++;
        $display("FAIL contention_grant%0d: gnt=%b want %b", k, {gnt0, gnt1}, want);
      end
      tick();
      tick();
      checks++;
      if ({ack0, ack1} !== want || {gnt0, gnt1} !== want) begin
        errors++;
        $display("FAIL contention_ack%0d: ack=%b gnt=%b want %b", k, {ack0, ack1}, {gnt0, gnt1}, want);
      end
      if (k == 3) begin
        req0 = 0; req1 = 0;
      end
      tick();
    end
    tick();
  endtask

  task automatic test_abort();
    req0 = 1;
    tick();
    req0 = 0;
    tick();
    tick();
    checks++;
    if ({ack0, ack1, gnt0} !== 3'b101) begin
      errors++;
      $display("FAIL abort_ack: ack=%b gnt0=%b want 10 1", {ack0, ack1}, gnt0);
    end
    tick();
    tick();
    checks++;
    if ({gnt0, gnt1, mem_cs, ack0, ack1} !== 5'b0) begin
      errors++;
      $display("FAIL abort_after: ctl=%b want 00000", {gnt0, gnt1, mem_cs, ack0, ack1});
    end
  endtask

  task automatic test_reset_mid_access();
    req1 = 1;
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if ({gnt0, gnt1, mem_cs, ack0, ack1} !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid_access: ctl=%b want 00000", {gnt0, gnt1, mem_cs, ack0, ack1});
    end
    tick();
    reset = 1'b0;
    req0 = 1;
    tick();
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL reset_first_grant: gnt=%b want 10", {gnt0, gnt1});
    end
    req0 = 0; req1 = 0;
    tick();
    tick();
    checks++;
    if ({ack0, ack1} !== 2'b10) begin
      errors++;
      $display("FAIL reset_first_ack: ack=%b want 10", {ack0, ack1});
    end
    tick();
  endtask

`ifdef MEM_ARB_LOCK_EN
  task automatic test_lock();
    logic [1:0] want;
    req0 = 1; req1 = 1; lock0 = 0; lock1 = 1;
    for (int k = 0; k < 3; k++) begin
      want = (k < 2) ? 2'b01 : 2'b10;
      tick();
      checks++;
      if ({gnt0, gnt1} !== want) begin
        errors++;
        $display("FAIL lock_grant%0d: gnt=%b want %b", k, {gnt0, gnt1}, want);
      end
      lock1 = 0;
      if (k == 2) begin
        req0 = 0; req1 = 0;
      end
      tick();
      tick();
      tick();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_write();
    test_contention();
    test_abort();
    test_reset_mid_access();
`ifdef MEM_ARB_LOCK_EN
    test_lock();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  always @(negedge clock) begin
    if (gnt0 && gnt1) begin
      errors++;
      $display("FAIL gnt_overlap: gnt=%b want not 11", {gnt0, gnt1});
    end
    if (ack0 && ack1) begin
      errors++;
      $display("FAIL ack_overlap: ack=%b want not 11", {ack0, ack1});
    end
  end
endmodule
